// File: rtl/aes_controller_output.sv
// Output stage of the AES controller: serializes result blocks from the output FIFO into
// AXI-Stream beats, with a one-block skid register so consecutive blocks stream without bubbles.
module aes_controller_output #(
  parameter int BUS_DATA_WIDTH  = 32,
  parameter int FIFO_DATA_WIDTH = 128,
  parameter int BLK_CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fifo_read_tvalid,
  output logic                         fifo_read_tready,
  input  logic [FIFO_DATA_WIDTH-1:0]   fifo_rdata,
  input  logic                         fifo_rlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [BUS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [BUS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic                         out_busy,
  output logic                         pkt_done,
  output logic [BLK_CNT_WIDTH-1:0]     blk_count
);

  // state     | meaning
  // IDLE      | shift and skid registers both empty
  // SEND      | shift register holds a block, skid empty
  // SEND_FULL | shift and skid both hold a block

  localparam int WORDS_PER_BLK = FIFO_DATA_WIDTH / BUS_DATA_WIDTH;
  localparam int IDX_W = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLK - 1);

  typedef enum logic [1:0] {IDLE, SEND, SEND_FULL} state_t;

  state_t state, state_nxt;

  logic [FIFO_DATA_WIDTH-1:0] shift_data, skid_data;
  logic                       shift_last, skid_last;
  logic [IDX_W-1:0]           idx;
  logic [WORDS_PER_BLK-1:0][BUS_DATA_WIDTH-1:0] shift_words;

  logic fifo_hs, beat_hs, final_hs;
  logic load_shift_fifo, load_shift_skid, load_skid;

  assign shift_words = shift_data;

  // ready depends only on the state register and reset, never on the FIFO inputs
  assign fifo_read_tready = (state != SEND_FULL) && !reset;
  assign m_axis_tvalid    = (state != IDLE);
  assign m_axis_tdata     = shift_words[idx];
  assign m_axis_tkeep     = '1;
  assign m_axis_tlast     = m_axis_tvalid && shift_last && (idx == LAST_IDX);
  assign out_busy         = (state != IDLE);

  assign fifo_hs  = fifo_read_tvalid && fifo_read_tready;
  assign beat_hs  = m_axis_tvalid && m_axis_tready;
  assign final_hs = beat_hs && (idx == LAST_IDX);

  always_comb begin
    state_nxt       = state;
    load_shift_fifo = 1'b0;
    load_shift_skid = 1'b0;
    load_skid       = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_hs) begin
          load_shift_fifo = 1'b1;
          state_nxt       = SEND;
        end
      end
      SEND: begin
        if (final_hs) begin
          if (fifo_hs) load_shift_fifo = 1'b1;
          else         state_nxt       = IDLE;
        end else if (fifo_hs) begin
          load_skid = 1'b1;
          state_nxt = SEND_FULL;
        end
      end
      SEND_FULL: begin
        if (final_hs) begin
          load_shift_skid = 1'b1;
          state_nxt       = SEND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shift_data <= '0;
      shift_last <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      idx        <= '0;
      blk_count  <= '0;
      pkt_done   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pkt_done <= final_hs && shift_last;
      if (load_shift_fifo) begin
        shift_data <= fifo_rdata;
        shift_last <= fifo_rlast;
      end else if (load_shift_skid) begin
        shift_data <= skid_data;
        shift_last <= skid_last;
      end
      if (load_skid) begin
        skid_data <= fifo_rdata;
        skid_last <= fifo_rlast;
      end
      if (final_hs)     idx <= '0;
      else if (beat_hs) idx <= idx + IDX_W'(1);
      // the block that carries tlast closes the packet, so the count restarts
      if (final_hs)
        blk_count <= shift_last ? '0 : blk_count + BLK_CNT_WIDTH'(1);
    end
  end

endmodule
